steer_en_ctrl: RTL and testbench
================================

Name: steer_en_ctrl

Overview:
- Consumes the left/right load-cell readings produced by the A2D interface and decides whether a rider is present and balanced.
- Drives en_steer to the steering/PID path and rider_off to the motor/power logic.
- A dwell timer requires balanced weight for about 1.34 s at 50 MHz before steering is enabled.
- Pure sequential control: a 3-state FSM, a timer and registered threshold compares.

Parameters:
- MIN_RIDER_WT, 12'h200, total weight above which a rider is considered on.
- WT_HYST, 12'h040, hysteresis; the rider is off when sum < MIN_RIDER_WT - WT_HYST.
- FAST_SIM, 0, when 1 the dwell timer uses 15 bits instead of 26.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-high
- lft_ld  in  12  left load-cell reading (unsigned)
- rght_ld  in  12  right load-cell reading (unsigned)
- en_steer  out  1  high while steering is permitted
- rider_off  out  1  high while no rider is detected

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All flops clear immediately on rst=1.
- Reset values: state=IDLE, timer=0, en_steer=0, rider_off=1.
- Inputs are registered once (lft_q, rght_q) on every clk.
- All compares use the registered inputs, so the FSM reacts 2 clk edges after an input change.
- Arithmetic, unsigned and zero-extended, with no truncation:
  - sum = lft_q + rght_q, 13 bits.
  - diff = |lft_q - rght_q|, 12 bits.
  - on = sum > MIN_RIDER_WT (strict).
  - off = sum < (MIN_RIDER_WT - WT_HYST) (strict). Between the two thresholds = hold current on/off status.
  - unbal_1_4 = (diff*4) > sum, computed at 14 bits.
  - unbal_15_16 = (diff*16) > (sum*15), computed at 17 bits. Equality counts as balanced in both compares.
- Timer:
  - Width is 26 bits when FAST_SIM=0, 15 bits when FAST_SIM=1.
  - Counts up by 1 each clk while state=WAIT.
  - Cleared on every transition into WAIT, and whenever unbal_1_4 is seen in WAIT.
  - tmr_full = all ones. It saturates and never wraps.
- FSM, priority top-down within each state:
  - IDLE:
    - on → WAIT, timer cleared.
    - else stay in IDLE.
  - WAIT:
    - off → IDLE.
    - unbal_1_4 → stay in WAIT, timer cleared.
    - tmr_full → STEER_EN.
    - else stay in WAIT, timer increments.
  - STEER_EN:
    - off → IDLE.
    - unbal_15_16 → WAIT, timer cleared.
    - else stay in STEER_EN.
- Outputs are Moore, decoded from registered state, glitch-free:
  - en_steer = (state == STEER_EN).
  - rider_off = (state == IDLE).
- Boundaries:
  - sum exactly MIN_RIDER_WT does not leave IDLE.
  - sum exactly MIN_RIDER_WT - WT_HYST does not force IDLE.
  - off and unbal asserted together: off wins.
  - Timer reaching full on the same cycle unbal_1_4 is asserted: unbal wins (clear, no enable).
  - Max inputs (12'hFFF both) give sum=13'h1FFE with no overflow.
  - rst mid-WAIT or mid-STEER_EN: en_steer drops in the same cycle (async) and rider_off rises; the FSM restarts from IDLE once rst is released.
- Readings update only every few microseconds, so stale samples between A2D updates are acceptable. No valid strobe is used.

Test Plan:
- Reset check: assert rst with any inputs → en_steer=0, rider_off=1 immediately. Release rst with lft=rght=0 → both outputs stay unchanged.
- Rider mounts balanced (FAST_SIM=1): lft=rght=12'h180, sum=12'h300.
  - rider_off falls 3 clks after the input change (1 input register + IDLE→WAIT + output decode).
  - en_steer rises exactly 32768 WAIT cycles later.
- Unbalanced mount: lft=12'h300, rght=12'h080 (diff=0x280, sum=0x380, 4*diff > sum) → remain in WAIT, en_steer never asserts.
  - Then set lft=rght=0x1C0 → the full 32768-cycle dwell restarts from 0.
- Step-off hysteresis, starting in STEER_EN:
  - Drop sum to 12'h1D0 (inside the hysteresis band) → en_steer stays 1.
  - Drop sum to 12'h1B0 → IDLE: en_steer=0, rider_off=1.
- Severe lean, starting in STEER_EN: lft=12'h3F8, rght=12'h008 (16*diff > 15*sum) → en_steer falls and the FSM is in WAIT.
  - Exact 15/16 boundary: lft=0x3E0, rght=0x020 (16*0x3C0 = 0x3C00 = 15*0x400) → en_steer stays 1.
- Async reset mid-STEER_EN: pulse rst for less than 1 clk between edges → en_steer=0 and rider_off=1 within that pulse.
  - Re-entry into STEER_EN then needs the full dwell again.

Source files
------------

// File: rtl/steer_en_ctrl.sv
// Rider-presence and balance controller: gates steering behind a balanced-weight dwell
// and flags rider-off to the power logic.
module steer_en_ctrl #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter bit          FAST_SIM     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int DATA_W = 12;
    localparam int TMR_W  = FAST_SIM ? 15 : 26;

    localparam logic [DATA_W:0] ON_THR  = {1'b0, MIN_RIDER_WT};
    localparam logic [DATA_W:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    typedef enum logic [1:0] {IDLE, WAIT, STEER_EN} state_t;

    logic [DATA_W-1:0] lft_p0, rght_p0;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
    logic              on_thr, off_thr, unbal_1_4, unbal_15_16, tmr_full;
    state_t            state_p1;
    logic [TMR_W-1:0]  tmr_p1;

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: register raw load-cell readings
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_p0  <= '0;
            rght_p0 <= '0;
        end else begin
            lft_p0  <= lft_ld;
            rght_p0 <= rght_ld;
        end
    end

    always_comb begin
        sum         = {1'b0, lft_p0} + {1'b0, rght_p0};
        diff        = (lft_p0 >= rght_p0) ? (lft_p0 - rght_p0) : (rght_p0 - lft_p0);
        on_thr      = sum > ON_THR;
        off_thr     = sum < OFF_THR;
        unbal_1_4   = {diff, 2'b00} > {1'b0, sum};
        unbal_15_16 = {1'b0, diff, 4'b0000} > (({4'b0000, sum} << 4) - {4'b0000, sum});
        tmr_full    = &tmr_p1;
    end

    // Stage p1: FSM and dwell timer; outputs registered from state one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1  <= IDLE;
            tmr_p1    <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            en_steer  <= (state_p1 == STEER_EN);
            rider_off <= (state_p1 == IDLE);
            case (state_p1)
                IDLE: begin
                    if (on_thr) begin
                        state_p1 <= WAIT;
                        tmr_p1   <= '0;
                    end
                end
                WAIT: begin
                    if (off_thr)
                        state_p1 <= IDLE;
                    else if (unbal_1_4)
                        tmr_p1 <= '0;
                    else if (tmr_full)
                        state_p1 <= STEER_EN;
                    else
                        tmr_p1 <= sat_inc(tmr_p1);
                end
                STEER_EN: begin
                    if (off_thr)
                        state_p1 <= IDLE;
                    else if (unbal_15_16) begin
                        state_p1 <= WAIT;
                        tmr_p1   <= '0;
                    end
                end
                default: state_p1 <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl: two FAST_SIM instances share load inputs,
// with separate resets so one can be reset while the other stays engaged.
module tb_steer_en_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [11:0] lft, rght;
    logic        en_a, roff_a, en_b, roff_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    steer_en_ctrl #(.FAST_SIM(1'b1)) u_dut_a (
        .clk(clk), .rst(rst_a), .lft_ld(lft), .rght_ld(rght),
        .en_steer(en_a), .rider_off(roff_a)
    );

    steer_en_ctrl #(.FAST_SIM(1'b1)) u_dut_b (
        .clk(clk), .rst(rst_b), .lft_ld(lft), .rght_ld(rght),
        .en_steer(en_b), .rider_off(roff_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [11:0] l, input logic [11:0] r);
        lft  = l;
        rght = r;
    endtask

    task automatic test_reset;
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_in(12'($urandom), 12'($urandom));
        #2;
        n_cmp++; if (en_a !== 1'b0)   begin n_bad++; $display("FAIL rst_en_a: got %b want 0", en_a); end
        n_cmp++; if (roff_a !== 1'b1) begin n_bad++; $display("FAIL rst_roff_a: got %b want 1", roff_a); end
        n_cmp++; if (en_b !== 1'b0)   begin n_bad++; $display("FAIL rst_en_b: got %b want 0", en_b); end
        n_cmp++; if (roff_b !== 1'b1) begin n_bad++; $display("FAIL rst_roff_b: got %b want 1", roff_b); end
        tick(2);
        set_in(12'h000, 12'h000);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(6);
        n_cmp++; if (en_a !== 1'b0)   begin n_bad++; $display("FAIL rel_en_a: got %b want 0", en_a); end
        n_cmp++; if (roff_a !== 1'b1) begin n_bad++; $display("FAIL rel_roff_a: got %b want 1", roff_a); end
        n_cmp++; if (en_b !== 1'b0)   begin n_bad++; $display("FAIL rel_en_b: got %b want 0", en_b); end
        n_cmp++; if (roff_b !== 1'b1) begin n_bad++; $display("FAIL rel_roff_b: got %b want 1", roff_b); end
    endtask

    task automatic test_mount;
        int cnt;
        set_in(12'h180, 12'h180);
        tick(2);
        n_cmp++; if (roff_a !== 1'b1) begin n_bad++; $display("FAIL mount_roff_edge2: got %b want 1", roff_a); end
        tick(1);
        n_cmp++; if (roff_a !== 1'b0) begin n_bad++; $display("FAIL mount_roff_edge3: got %b want 0", roff_a); end
        cnt = 0;
        while (en_a !== 1'b1 && cnt < 40000) begin
            tick(1);
            cnt++;
        end
        n_cmp++; if (cnt !== 32768) begin n_bad++; $display("FAIL mount_dwell: got %0d cycles want 32768", cnt); end
    endtask

    task automatic test_async_reset;
        #1 rst_b = 1'b1;
        #2;
        n_cmp++; if (en_b !== 1'b0)   begin n_bad++; $display("FAIL pulse_en_b: got %b want 0", en_b); end
        n_cmp++; if (roff_b !== 1'b1) begin n_bad++; $display("FAIL pulse_roff_b: got %b want 1", roff_b); end
        #2 rst_b = 1'b0;
        tick(3);
        n_cmp++; if (en_a !== 1'b1)   begin n_bad++; $display("FAIL pulse_en_a_kept: got %b want 1", en_a); end
    endtask

    task automatic test_lean;
        set_in(12'h3E0, 12'h020);
        tick(5);
        n_cmp++; if (en_a !== 1'b1) begin n_bad++; $display("FAIL lean_15_16_equal: got %b want 1", en_a); end
        set_in(12'h3F8, 12'h008);
        tick(2);
        n_cmp++; if (en_a !== 1'b1) begin n_bad++; $display("FAIL lean_edge2: got %b want 1", en_a); end
        tick(1);
        n_cmp++; if (en_a !== 1'b0)   begin n_bad++; $display("FAIL lean_en: got %b want 0", en_a); end
        n_cmp++; if (roff_a !== 1'b0) begin n_bad++; $display("FAIL lean_wait_roff: got %b want 0", roff_a); end
    endtask

    task automatic test_unbal_restart;
        int cnt, cnt_b;
        set_in(12'h300, 12'h080);
        tick(2000);
        n_cmp++; if (en_a !== 1'b0)   begin n_bad++; $display("FAIL unbal_en_a: got %b want 0", en_a); end
        n_cmp++; if (roff_a !== 1'b0) begin n_bad++; $display("FAIL unbal_roff_a: got %b want 0", roff_a); end
        n_cmp++; if (en_b !== 1'b0)   begin n_bad++; $display("FAIL unbal_en_b: got %b want 0", en_b); end
        set_in(12'h1C0, 12'h1C0);
        cnt   = 0;
        cnt_b = -1;
        while ((en_a !== 1'b1 || cnt_b < 0) && cnt < 40000) begin
            tick(1);
            cnt++;
            if (en_b === 1'b1 && cnt_b < 0) cnt_b = cnt;
        end
        n_cmp++; if (cnt !== 32770)   begin n_bad++; $display("FAIL restart_dwell_a: got %0d cycles want 32770", cnt); end
        n_cmp++; if (cnt_b !== 32770) begin n_bad++; $display("FAIL reentry_dwell_b: got %0d cycles want 32770", cnt_b); end
    endtask

    task automatic test_step_off;
        set_in(12'h0E8, 12'h0E8);
        tick(5);
        n_cmp++; if (en_a !== 1'b1) begin n_bad++; $display("FAIL hyst_band: got %b want 1", en_a); end
        set_in(12'h0E0, 12'h0E0);
        tick(5);
        n_cmp++; if (en_a !== 1'b1) begin n_bad++; $display("FAIL hyst_exact_off_thr: got %b want 1", en_a); end
        set_in(12'h0D8, 12'h0D8);
        tick(2);
        n_cmp++; if (en_a !== 1'b1) begin n_bad++; $display("FAIL stepoff_edge2: got %b want 1", en_a); end
        tick(1);
        n_cmp++; if (en_a !== 1'b0)   begin n_bad++; $display("FAIL stepoff_en: got %b want 0", en_a); end
        n_cmp++; if (roff_a !== 1'b1) begin n_bad++; $display("FAIL stepoff_roff: got %b want 1", roff_a); end
        n_cmp++; if (roff_b !== 1'b1) begin n_bad++; $display("FAIL stepoff_roff_b: got %b want 1", roff_b); end
    endtask

    task automatic test_boundaries;
        set_in(12'h100, 12'h100);
        tick(10);
        n_cmp++; if (roff_a !== 1'b1) begin n_bad++; $display("FAIL exact_on_thr: got %b want 1", roff_a); end
        set_in(12'hFFF, 12'hFFF);
        tick(3);
        n_cmp++; if (roff_a !== 1'b0) begin n_bad++; $display("FAIL max_inputs: got %b want 0", roff_a); end
        set_in(12'h1B0, 12'h000);
        tick(3);
        n_cmp++; if (roff_a !== 1'b1) begin n_bad++; $display("FAIL off_beats_unbal: got %b want 1", roff_a); end
        n_cmp++; if (en_a !== 1'b0)   begin n_bad++; $display("FAIL off_beats_unbal_en: got %b want 0", en_a); end
    endtask

    initial begin
        test_reset();
        test_mount();
        test_async_reset();
        test_lean();
        test_unbal_restart();
        test_step_off();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
